fp32_acc: RTL

Sequential IEEE-754 single-precision accumulator that sits directly downstream of the FP32 multiplier and sums its product stream into a running total. It supports multiply-accumulate and dot-product flows. Each operand is taken through a valid/ready handshake and added to an internal accumulator by a fixed-latency multi-cycle datapath with round-to-nearest-even. The last operand of a group publishes the final sum and clears the accumulator.

---
 rtl/fp32_acc_if.sv | 16 +
 rtl/fp32_acc.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp32_acc_if.sv
// Operand stream and result bus of the FP32 accumulator.
// The master feeds operands; the slave (the accumulator) publishes acc/sum.
interface fp32_acc_if;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_last;
  logic        in_ready;
  logic [31:0] acc;
  logic [31:0] sum_out;
  logic        sum_valid;

  modport master (output in_valid, in_data, in_last,
                  input  in_ready, acc, sum_out, sum_valid);
  modport slave  (input  in_valid, in_data, in_last,
                  output in_ready, acc, sum_out, sum_valid);
endinterface

// File: rtl/fp32_acc.sv
// Sequential FP32 accumulator: one operand per 7 cycles, fixed 6-edge latency,
// round-to-nearest-even, group close publishes sum_out and clears acc.
module fp32_acc (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  fp32_acc_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, PACK} state_t;

  state_t state_q, state_d;
  logic   ready, accept, commit;

  logic [31:0] acc_q, sum_q;
  logic        sum_vld_q;
  logic [31:0] op_q;
  logic        last_q;

  // stage registers
  logic               sa_q, sb_q, spec_q, negz_q;
  logic [31:0]        spec_val_q;
  logic signed [9:0]  ea_q, eb_q, e_al_q, e_add_q, e_n_q, e_r_q;
  logic [26:0]        ma_q, mb_q, mx_q, my_q, m_n_q;
  logic               s_add_q, zero_q;
  logic [27:0]        r_add_q;
  logic [23:0]        m_r_q;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst || clr) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = UNPACK;
      UNPACK:  state_d = ALIGN;
      ALIGN:   state_d = ADD;
      ADD:     state_d = NORM;
      NORM:    state_d = ROUND;
      ROUND:   state_d = PACK;
      PACK:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready  = (state_q == IDLE) && !clr && !rst;
    commit = (state_q == PACK);
  end

  assign accept        = bus.in_valid && ready;
  assign bus.in_ready  = ready;
  assign bus.acc       = acc_q;
  assign bus.sum_out   = sum_q;
  assign bus.sum_valid = sum_vld_q;

  always_ff @(posedge clk) begin
    if (accept) begin
      op_q   <= bus.in_data;
      last_q <= bus.in_last;
    end
  end

  // ---------------- UNPACK ----------------
  logic               u_spec, u_negz;
  logic [31:0]        u_spec_val;
  logic signed [9:0]  u_ea, u_eb;
  logic [26:0]        u_ma, u_mb;
  logic               a_nan, b_nan, a_inf, b_inf;

  always_comb begin
    a_nan = (&acc_q[30:23]) && (|acc_q[22:0]);
    b_nan = (&op_q[30:23])  && (|op_q[22:0]);
    a_inf = (&acc_q[30:23]) && !(|acc_q[22:0]);
    b_inf = (&op_q[30:23])  && !(|op_q[22:0]);
    u_ea  = (acc_q[30:23] == 8'd0) ? -10'sd126 : $signed({2'b00, acc_q[30:23]}) - 10'sd127;
    u_eb  = (op_q[30:23]  == 8'd0) ? -10'sd126 : $signed({2'b00, op_q[30:23]})  - 10'sd127;
    u_ma  = {|acc_q[30:23], acc_q[22:0], 3'b000};
    u_mb  = {|op_q[30:23],  op_q[22:0],  3'b000};
    u_negz = acc_q[31] && op_q[31] && !(|acc_q[30:0]) && !(|op_q[30:0]);
    u_spec     = 1'b0;
    u_spec_val = 32'h0;
    if (a_nan || b_nan || (a_inf && b_inf && (acc_q[31] != op_q[31]))) begin
      u_spec     = 1'b1;
      u_spec_val = 32'hFFC0_0000;
    end else if (a_inf) begin
      u_spec     = 1'b1;
      u_spec_val = acc_q;
    end else if (b_inf) begin
      u_spec     = 1'b1;
      u_spec_val = op_q;
    end
  end

  // ---------------- ALIGN ----------------
  // Right shift keeping a sticky OR of everything shifted out.
  function automatic logic [26:0] shr_sticky(input logic [26:0] m, input logic [9:0] d);
    logic lost;
    if (d > 10'd26) return {26'b0, |m};
    lost = |(m & ~({27{1'b1}} << d));
    return (m >> d) | {26'b0, lost};
  endfunction

  logic [9:0]         dif_ab, dif_ba;
  logic [26:0]        al_mx, al_my;
  logic signed [9:0]  al_e;

  always_comb begin
    dif_ab = ea_q - eb_q;
    dif_ba = eb_q - ea_q;
    if (ea_q >= eb_q) begin
      al_e  = ea_q;
      al_mx = ma_q;
      al_my = shr_sticky(mb_q, dif_ab);
    end else begin
      al_e  = eb_q;
      al_mx = shr_sticky(ma_q, dif_ba);
      al_my = mb_q;
    end
  end

  // ---------------- ADD ----------------
  logic [27:0] ad_r;
  logic        ad_s;

  always_comb begin
    if (sa_q == sb_q) begin
      ad_r = {1'b0, mx_q} + {1'b0, my_q};
      ad_s = sa_q;
    end else if (mx_q >= my_q) begin
      ad_r = {1'b0, mx_q - my_q};
      ad_s = sa_q;
    end else begin
      ad_r = {1'b0, my_q - mx_q};
      ad_s = sb_q;
    end
  end

  // ---------------- NORM ----------------
  logic [4:0]         lz;
  logic signed [9:0]  lim, lzs, sh;
  logic [26:0]        nm_m;
  logic signed [9:0]  nm_e;
  logic               nm_zero;

  always_comb begin
    lz = 5'd27;
    for (int i = 0; i < 27; i++)
      if (r_add_q[i]) lz = 5'(26 - i);
    lzs     = $signed({5'b0, lz});
    // never normalise below the denormal exponent
    lim     = e_add_q + 10'sd126;
    sh      = (lzs > lim) ? lim : lzs;
    nm_zero = (r_add_q == 28'd0);
    if (r_add_q[27]) begin
      nm_m = {r_add_q[27:2], r_add_q[1] | r_add_q[0]};
      nm_e = e_add_q + 10'sd1;
    end else begin
      nm_m = r_add_q[26:0] << sh;
      nm_e = e_add_q - sh;
    end
  end

  // ---------------- ROUND ----------------
  logic        rd_inc;
  logic [24:0] rd_t;
  logic [23:0] rd_m;
  logic signed [9:0] rd_e;

  always_comb begin
    rd_inc = m_n_q[2] && (m_n_q[1] || m_n_q[0] || m_n_q[3]);
    rd_t   = {1'b0, m_n_q[26:3]} + {24'd0, rd_inc};
    if (rd_t[24]) begin
      rd_m = rd_t[24:1];
      rd_e = e_n_q + 10'sd1;
    end else begin
      rd_m = rd_t[23:0];
      rd_e = e_n_q;
    end
  end

  // ---------------- PACK ----------------
  logic [31:0] result;

  always_comb begin
    if (spec_q)
      result = spec_val_q;
    else if (zero_q)
      result = negz_q ? 32'h8000_0000 : 32'h0000_0000;
    else if (e_r_q > 10'sd127)
      result = {s_add_q, 8'hFF, 23'd0};
    else if (!m_r_q[23])
      result = {s_add_q, 8'h00, m_r_q[22:0]};
    else
      result = {s_add_q, 8'(e_r_q + 10'sd127), m_r_q[22:0]};
  end

  // Stage registers only load in their own state; values hold afterwards.
  always_ff @(posedge clk) begin
    case (state_q)
      UNPACK: begin
        sa_q <= acc_q[31];  sb_q <= op_q[31];
        ea_q <= u_ea;       eb_q <= u_eb;
        ma_q <= u_ma;       mb_q <= u_mb;
        spec_q <= u_spec;   spec_val_q <= u_spec_val;
        negz_q <= u_negz;
      end
      ALIGN: begin
        e_al_q <= al_e;  mx_q <= al_mx;  my_q <= al_my;
      end
      ADD: begin
        e_add_q <= e_al_q;  r_add_q <= ad_r;  s_add_q <= ad_s;
      end
      NORM: begin
        e_n_q <= nm_e;  m_n_q <= nm_m;  zero_q <= nm_zero;
      end
      ROUND: begin
        e_r_q <= rd_e;  m_r_q <= rd_m;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= 32'h0;
      sum_q     <= 32'h0;
      sum_vld_q <= 1'b0;
    end else if (clr) begin
      acc_q     <= 32'h0;
      sum_vld_q <= 1'b0;
    end else begin
      sum_vld_q <= 1'b0;
      if (commit) begin
        if (last_q) begin
          sum_q     <= result;
          sum_vld_q <= 1'b1;
          acc_q     <= 32'h0;
        end else begin
          acc_q <= result;
        end
      end
    end
  end

endmodule
